// File: rtl/tiny_operand_feeder_x4.sv
// tiny_operand_feeder_x4
//   Upstream feeder for the tiny basic-block x4 row. Two operand FIFOs (A, B)
//   hold 64-bit words (4 x bf16). An FSM frames each operation: it pairs A/B
//   heads onto east_out/north_out and holds stage_start high from the cycle
//   after start until the downstream pipe has drained.
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   start/frame_len/unary     frame request, sampled only in IDLE
//   a_tvalid/a_tdata/a_tready A operand stream (ready = FIFO not full)
//   b_tvalid/b_tdata/b_tready B operand stream
//   stage_start               frame-active strobe (RUN + DRAIN)
//   east_out_*/north_out_*    issued A/B beats, zero on bubble cycles
//   busy                      FSM not in IDLE
//   done                      one-cycle pulse at frame end

// Single operand FIFO. Pointers carry one extra wrap bit so full/empty
// come from the MSB compare. head is the raw memory read at rd_ptr; the
// caller must not pop while empty.
module tiny_operand_feeder_fifo #(
   parameter int DEPTH = 8,
   parameter int W     = 64
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] head,
   output logic         ready,
   output logic         empty
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  wr_ptr, rd_ptr, wr_nxt, rd_nxt;
   logic         do_push;

   // ready is registered from the next-state pointers, so it is exact for
   // the current cycle and a full FIFO is never written.
   assign do_push = push & ready;
   assign wr_nxt  = wr_ptr + (AW+1)'(do_push);
   assign rd_nxt  = rd_ptr + (AW+1)'(pop);
   assign empty   = (wr_ptr == rd_ptr);
   assign head    = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         ready  <= 1'b0;
      end else begin
         wr_ptr <= wr_nxt;
         rd_ptr <= rd_nxt;
         ready  <= !((wr_nxt[AW] != rd_nxt[AW]) &&
                     (wr_nxt[AW-1:0] == rd_nxt[AW-1:0]));
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end
endmodule

module tiny_operand_feeder_x4 #(
   parameter int DEPTH        = 8,
   parameter int DRAIN_CYCLES = 32,
   parameter int LEN_W        = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [LEN_W-1:0] frame_len,
   input  logic             unary,
   input  logic             a_tvalid,
   input  logic [63:0]      a_tdata,
   output logic             a_tready,
   input  logic             b_tvalid,
   input  logic [63:0]      b_tdata,
   output logic             b_tready,
   output logic             stage_start,
   output logic             east_out_tvalid,
   output logic [63:0]      east_out_tdata,
   output logic             north_out_tvalid,
   output logic [63:0]      north_out_tdata,
   output logic             busy,
   output logic             done
);
   localparam int DC_W = $clog2(DRAIN_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t           state;
   logic [LEN_W-1:0] rem;
   logic [DC_W-1:0]  drain_cnt;
   logic             is_unary;

   // index 0 = A operand, 1 = B operand
   logic [1:0]       op_tvalid, op_pop, op_ready, op_empty;
   logic [1:0][63:0] op_tdata, op_head;
   logic             issue;

   assign op_tvalid = {b_tvalid, a_tvalid};
   assign op_tdata  = {b_tdata, a_tdata};
   assign a_tready  = op_ready[0];
   assign b_tready  = op_ready[1];

   for (genvar g = 0; g < 2; g++) begin : g_op
      tiny_operand_feeder_fifo #(.DEPTH(DEPTH), .W(64)) u_fifo (
         .clk   (clk),
         .rst   (rst),
         .push  (op_tvalid[g]),
         .din   (op_tdata[g]),
         .pop   (op_pop[g]),
         .head  (op_head[g]),
         .ready (op_ready[g]),
         .empty (op_empty[g])
      );
   end

   // Unary ops never touch B, so B contents survive for later frames.
   assign issue  = (state == RUN) && !op_empty[0] && (is_unary || !op_empty[1]);
   assign op_pop = {issue && !is_unary, issue};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state            <= IDLE;
         rem              <= '0;
         drain_cnt        <= '0;
         is_unary         <= 1'b0;
         stage_start      <= 1'b0;
         busy             <= 1'b0;
         done             <= 1'b0;
         east_out_tvalid  <= 1'b0;
         east_out_tdata   <= '0;
         north_out_tvalid <= 1'b0;
         north_out_tdata  <= '0;
      end else begin
         done             <= 1'b0;
         east_out_tvalid  <= issue;
         east_out_tdata   <= issue ? op_head[0] : '0;
         north_out_tvalid <= issue && !is_unary;
         north_out_tdata  <= (issue && !is_unary) ? op_head[1] : '0;
         case (state)
            IDLE: begin
               if (start) begin
                  if (frame_len != '0) begin
                     rem         <= frame_len;
                     is_unary    <= unary;
                     state       <= RUN;
                     stage_start <= 1'b1;
                     busy        <= 1'b1;
                  end else begin
                     done <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (issue) begin
                  rem <= rem - LEN_W'(1);
                  if (rem == LEN_W'(1)) begin
                     state     <= DRAIN;
                     drain_cnt <= DC_W'(DRAIN_CYCLES);
                  end
               end
            end
            DRAIN: begin
               drain_cnt <= drain_cnt - DC_W'(1);
               if (drain_cnt == DC_W'(1)) begin
                  state       <= IDLE;
                  stage_start <= 1'b0;
                  busy        <= 1'b0;
                  done        <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_tiny_operand_feeder_x4.sv
// Self-checking bench for tiny_operand_feeder_x4. The reference model is a
// pair of word queues (what was accepted on each stream, in order) plus
// frame-level timing rules: beat count, first-beat latency, drain length,
// stage_start window and done pulse width.
module tb_tiny_operand_feeder_x4;
   localparam int DEPTH = 8, DRAIN = 32, LEN_W = 16;

   logic             clk = 0, rst = 0, start = 0, unary = 0;
   logic [LEN_W-1:0] frame_len = '0;
   logic             a_tvalid = 0, b_tvalid = 0;
   logic [63:0]      a_tdata = '0, b_tdata = '0;
   logic             a_tready, b_tready, stage_start, busy, done;
   logic             east_out_tvalid, north_out_tvalid;
   logic [63:0]      east_out_tdata, north_out_tdata;

   int          n_cmp = 0, n_bad = 0, cyc = 0;
   logic [63:0] qa[$], qb[$];
   bit          cur_unary = 0;
   int          beats = 0, ss_cycles = 0, done_cnt = 0, done_cyc = 0;
   int          first_beat = 0, last_beat = 0;
   int          beat_cyc[$];

   tiny_operand_feeder_x4 #(.DEPTH(DEPTH), .DRAIN_CYCLES(DRAIN), .LEN_W(LEN_W)) dut (
      .clk(clk), .rst(rst), .start(start), .frame_len(frame_len), .unary(unary),
      .a_tvalid(a_tvalid), .a_tdata(a_tdata), .a_tready(a_tready),
      .b_tvalid(b_tvalid), .b_tdata(b_tdata), .b_tready(b_tready),
      .stage_start(stage_start),
      .east_out_tvalid(east_out_tvalid), .east_out_tdata(east_out_tdata),
      .north_out_tvalid(north_out_tvalid), .north_out_tdata(north_out_tdata),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Output monitor: every issued beat must be the oldest accepted word.
   always @(negedge clk) begin
      if (!rst) begin
         if (stage_start) ss_cycles++;
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
            chk("ss_low_at_done", stage_start, 0);
         end
         if (east_out_tvalid) begin
            if (beats == 0) first_beat = cyc;
            last_beat = cyc;
            beat_cyc.push_back(cyc);
            beats++;
            chk("ss_during_beat", stage_start, 1);
            if (qa.size() == 0) chk("east_extra_beat_qa_size", 64'(qa.size()), 1);
            else chk("east_data", east_out_tdata, qa.pop_front());
            chk("north_valid", north_out_tvalid, !cur_unary);
            if (!cur_unary) begin
               if (qb.size() == 0) chk("north_extra_beat_qb_size", 64'(qb.size()), 1);
               else chk("north_data", north_out_tdata, qb.pop_front());
            end else begin
               chk("north_data_unary", north_out_tdata, 0);
            end
         end else begin
            chk("bubble_north_valid", north_out_tvalid, 0);
            chk("bubble_data", east_out_tdata | north_out_tdata, 0);
         end
      end
   end

   task automatic nstep();
      @(negedge clk);
      #1;
   endtask

   // Push n random words on A (sel_b=0) or B (sel_b=1), holding each until
   // accepted, then idling gap cycles. Accepted words enter the model queue.
   task automatic push(input bit sel_b, input int n, input int gap);
      logic [63:0] w;
      bit rdy;
      int g;
      for (int i = 0; i < n; i++) begin
         w = {$urandom, $urandom};
         if (sel_b) begin b_tvalid = 1; b_tdata = w; end
         else       begin a_tvalid = 1; a_tdata = w; end
         g = 0;
         forever begin
            rdy = sel_b ? b_tready : a_tready;
            @(posedge clk);
            if (rdy || g > 500) break;
            nstep();
            g++;
         end
         if (rdy) begin
            if (sel_b) qb.push_back(w); else qa.push_back(w);
         end else begin
            chk("push_timeout", rdy, 1);
         end
         nstep();
         if (sel_b) begin b_tvalid = 0; b_tdata = '0; end
         else       begin a_tvalid = 0; a_tdata = '0; end
         repeat (gap) nstep();
      end
   endtask

   // p = cycle index at which the DUT samples start
   task automatic start_frame(input int len, input bit un, output int p);
      start = 1; frame_len = LEN_W'(len); unary = un;
      if (len != 0) cur_unary = un;
      beats = 0; ss_cycles = 0; done_cnt = 0; beat_cyc.delete();
      p = cyc + 1;
      nstep();
      start = 0; frame_len = '0; unary = 0;
      if (len != 0) chk("busy_in_frame", busy, 1);
   endtask

   task automatic finish_frame(input int p, input int len);
      int g = 0;
      while (done_cnt == 0 && g < 3000) begin nstep(); g++; end
      chk("done_seen", done_cnt, 1);
      nstep(); nstep();
      chk("done_pulse_width", done_cnt, 1);
      chk("beats_in_frame", beats, len);
      chk("busy_after_done", busy, 0);
      chk("stage_start_window", ss_cycles, done_cyc - p);
      if (len != 0) chk("drain_latency", done_cyc - last_beat, DRAIN);
      else          chk("zero_len_done_cycle", done_cyc, p);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_stage_start"}, stage_start, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_valids"}, {east_out_tvalid, north_out_tvalid}, 0);
      chk({tag, "_data"}, east_out_tdata | north_out_tdata, 0);
      chk({tag, "_treadys"}, {a_tready, b_tready}, 0);
   endtask

   initial begin
      int p, g;

      // reset
      #2 rst = 1;
      nstep();
      chk_all_zero("reset");
      nstep();
      rst = 0;
      nstep();
      chk("tready_after_reset", {a_tready, b_tready}, 2'b11);

      // prefetch: 4 A + 4 B buffered, binary len 4
      fork push(0, 4, 0); push(1, 4, 0); join
      nstep();
      start_frame(4, 0, p);
      finish_frame(p, 4);
      chk("prefetch_first_beat", first_beat, p + 1);
      chk("prefetch_last_beat", last_beat, p + 4);

      // unary: 3 A, 2 B preloaded; B must survive
      fork push(0, 3, 0); push(1, 2, 0); join
      nstep();
      start_frame(3, 1, p);
      finish_frame(p, 3);
      // the 2 preserved B words must be the next ones issued
      fork
         begin start_frame(2, 0, p); finish_frame(p, 2); end
         push(0, 2, 0);
      join

      // stall: B preloaded, A arrives 1 every 3 cycles
      push(1, 4, 0);
      fork
         begin start_frame(4, 0, p); finish_frame(p, 4); end
         push(0, 4, 2);
      join
      for (int i = 1; i < 4; i++)
         chk("stall_beat_spacing", beat_cyc[i] - beat_cyc[i-1], 3);

      // backpressure: 8 fill the A FIFO, the 9th waits for the first pop
      push(0, 8, 0);
      chk("a_tready_full", a_tready, 0);
      nstep(); nstep();
      chk("a_tready_full_held", a_tready, 0);
      fork
         begin start_frame(8, 1, p); finish_frame(p, 8); end
         push(0, 1, 0);
      join
      // the 9th word remains buffered for the next frame

      // zero-length frame: done only, no pops
      start_frame(0, 0, p);
      finish_frame(p, 0);

      // randomized frames
      for (int k = 0; k < 4; k++) begin
         int len;
         bit un;
         len = $urandom_range(1, 6);
         un  = 1'($urandom_range(0, 1));
         fork
            begin start_frame(len, un, p); finish_frame(p, len); end
            push(0, len, $urandom_range(0, 3));
            if (!un) push(1, len, $urandom_range(0, 3));
         join
      end

      // reset mid-frame after 2 beats (leftover A + 1 new A available)
      fork push(0, 1, 0); push(1, 4, 0); join
      nstep();
      start_frame(4, 0, p);
      g = 0;
      while (beats < 2 && g < 100) begin nstep(); g++; end
      chk("mid_frame_beats", beats, 2);
      nstep();
      #2 rst = 1;
      #1 chk_all_zero("async_reset");
      qa.delete(); qb.delete();
      nstep(); nstep();
      rst = 0;
      nstep();
      chk("tready_after_mid_reset", {a_tready, b_tready}, 2'b11);
      chk("no_done_on_abort", done_cnt, 0);
      fork
         begin start_frame(3, 0, p); finish_frame(p, 3); end
         push(0, 3, 1);
         push(1, 3, 0);
      join

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
